ps2_rx_fifo: RTL and testbench
==============================

# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver with input synchronisation, clock-glitch filtering, full frame checking (start, odd parity, stop) and a watchdog that discards stalled partial frames. Good bytes are pushed into a first-word-fall-through FIFO, so the keyboard/mouse decoder can drain scan codes at its own pace. Framing, parity and overflow failures are reported as sticky flags. The block sits between the PS/2 pins and the scan-code decoder, all in the slowClk domain.

## Interface
- FIFO_DEPTH, 8, byte entries; power of two, at least 2
- FILTER_LEN, 4, consecutive identical synchronised PS2clk samples required before the filtered clock changes; at least 1
- TIMEOUT_CYCLES, 2000, slowClk cycles without a filtered falling edge before a partial frame is abandoned
- slowClk  in  1  system clock; must be at least 20x the PS/2 clock rate
- reset  in  1  asynchronous, active-high
- PS2data  in  1  raw PS/2 data line, asynchronous
- PS2clk  in  1  raw PS/2 clock line, asynchronous
- rd_en  in  1  pop the head entry; ignored while valid=0
- err_clr  in  1  clears all sticky error flags
- dout  out  8  FIFO head byte; 0x00 while empty
- valid  out  1  FIFO not empty
- count  out  $clog2(FIFO_DEPTH)+1  number of stored bytes
- rx_pulse  out  1  one-cycle strobe when a good byte is pushed
- parity_err  out  1  sticky flag
- frame_err  out  1  sticky flag: bad start bit, bad stop bit, or timeout
- overflow  out  1  sticky flag: good byte dropped because the FIFO was full

## Operation
- Input path: two-flop synchroniser on each line, reset to 1. The filtered clock fclk (reset 1) takes the synchronised value only after FILTER_LEN consecutive equal samples. Edge = fclk transitions 1->0. Data is sampled from the synchronised PS2data in the edge cycle.
- FSM states: IDLE, DATA, PARITY, STOP. Reset and abort both go to IDLE.
- IDLE: on an edge with data=0, go to DATA with bit index 0. On an edge with data=1, set frame_err and stay in IDLE.
- DATA: shift data in LSB first, 8 edges; go to PARITY after bit 7.
- PARITY: capture the parity bit, go to STOP.
- STOP: on the edge, return to IDLE. The frame is evaluated in priority order:
  - stop=0: frame_err set, no push.
  - Otherwise, parity fails (ones in data+parity even): parity_err set, no push.
  - Otherwise the frame is good: push and strobe rx_pulse; if the FIFO is full, overflow is set and the byte is dropped.
- Watchdog: counts cycles in non-IDLE states and restarts on every edge. On reaching TIMEOUT_CYCLES: go to IDLE, set frame_err, discard the partial byte.
- FIFO: circular buffer with wrapping pointers; dout shows the head combinationally from registered storage.
  - Pop on rd_en & valid.
  - Push and pop in the same cycle while full: both succeed, no overflow, count unchanged.
  - Push while empty with rd_en high: rd_en is ignored.
- Sticky flags: set on their event, cleared by err_clr. If set and err_clr coincide, set wins.

## Timing
- Reset values: dout 0x00, valid 0, count 0, rx_pulse 0, all error flags 0, FSM IDLE, watchdog 0, pointers 0.
- Pin-to-edge latency: a PS2clk fall that stays stable is recognised as an edge 2+FILTER_LEN slowClk cycles after it reaches the pin.
- Push timing: if the stop-bit edge is in cycle N, then in cycle N+1 rx_pulse=1 for one cycle, valid=1, dout=byte, and count is incremented.
- Error flags rise in cycle N+1 after the offending edge or timeout cycle.
- Pop: with rd_en high in cycle M, the next entry (or 0x00 with valid=0) appears in cycle M+1.
- Reset asserted mid-frame: the partial frame is lost, FIFO contents are lost, and all outputs return to reset values asynchronously.

## Test plan
- Frame 0x1C with parity 0 and stop 1 -> one rx_pulse, valid=1, dout=0x1C, count=1, no flags. Pulse rd_en once -> valid=0, dout=0x00.
- Frame 0x1C with parity 1 -> parity_err=1, count=0, no rx_pulse. Pulse err_clr -> parity_err=0.
- Frame 0xAA with parity 1 and stop 0 -> frame_err=1, count=0. A following good 0xAA frame -> accepted, dout=0xAA.
- FIFO_DEPTH=8, nine good frames 0x01..0x09 with no reads -> count=8, overflow=1. Eight reads return 0x01..0x08 in order, then valid=0.
- Start bit plus 4 data bits, then PS2clk held high -> after TIMEOUT_CYCLES, frame_err=1 and FSM is IDLE. A following good 0x5A frame is received correctly.
- 2-cycle low glitch on PS2clk with FILTER_LEN=4 during DATA -> no bit shifted. The frame completes correctly. Separately, reset mid-frame -> all outputs return to reset values, and the next full frame is received.

Source files
------------

// File: rtl/ps2_rx_fifo_if.sv
// Decoder-side bus of the PS/2 receiver: FIFO read port, status strobe and sticky error flags.
// slave = receiver, master = scan-code decoder.
interface ps2_rx_fifo_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          rd_en;
    logic          err_clr;
    logic [7:0]    dout;
    logic          valid;
    logic [CW-1:0] count;
    logic          rx_pulse;
    logic          parity_err;
    logic          frame_err;
    logic          overflow;

    modport master (
        output rd_en, err_clr,
        input  dout, valid, count, rx_pulse, parity_err, frame_err, overflow
    );

    modport slave (
        input  rd_en, err_clr,
        output dout, valid, count, rx_pulse, parity_err, frame_err, overflow
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchroniser, clock glitch filter, frame checker with
// watchdog, and a first-word-fall-through byte FIFO with sticky error flags.
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic           slowClk,
    input  logic           reset,
    input  logic           PS2data,
    input  logic           PS2clk,
    ps2_rx_fifo_if.slave   bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
    logic          fclk_q, fclk_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    state_t        state_q, state_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [WW-1:0] wd_q, wd_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rx_pulse_q, rx_pulse_d;
    logic          parity_err_q, parity_err_d;
    logic          frame_err_q, frame_err_d;
    logic          overflow_q, overflow_d;

    logic fall, sdat, timeout, good, push, pop, full, not_empty;
    logic frame_set, par_set, ovf_set;

    // Filtered clock only follows the synchronised line after FILTER_LEN matching samples.
    always_comb begin
        clk_sync_d = {clk_sync_q[0], PS2clk};
        dat_sync_d = {dat_sync_q[0], PS2data};
        fclk_d     = fclk_q;
        filt_cnt_d = '0;
        if (clk_sync_q[1] != fclk_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1))
                fclk_d = clk_sync_q[1];
            else
                filt_cnt_d = filt_cnt_q + 1'b1;
        end
        fall = fclk_q & ~fclk_d;
        sdat = dat_sync_q[1];
    end

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        wd_d      = '0;
        frame_set = 1'b0;
        par_set   = 1'b0;
        good      = 1'b0;
        timeout   = (state_q != IDLE) && !fall && (wd_q == WW'(TIMEOUT_CYCLES - 1));
        if (state_q != IDLE && !fall)
            wd_d = wd_q + 1'b1;
        if (timeout) begin
            state_d   = IDLE;
            frame_set = 1'b1;
            wd_d      = '0;
        end else if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!sdat) begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        frame_set = 1'b1;
                    end
                end
                DATA: begin
                    shreg_d   = {sdat, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7)
                        state_d = PARITY;
                end
                PARITY: begin
                    par_d   = sdat;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!sdat)
                        frame_set = 1'b1;
                    else if (!(^{shreg_q, par_q}))
                        par_set = 1'b1;
                    else
                        good = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A full FIFO still accepts a byte when the head is popped in the same cycle.
    always_comb begin
        full      = (count_q == CW'(FIFO_DEPTH));
        not_empty = (count_q != '0);
        pop       = bus.rd_en & not_empty;
        push      = good & (~full | pop);
        ovf_set   = good & full & ~pop;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = shreg_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        rx_pulse_d   = push;
        parity_err_d = par_set   | (parity_err_q & ~bus.err_clr);
        frame_err_d  = frame_set | (frame_err_q  & ~bus.err_clr);
        overflow_d   = ovf_set   | (overflow_q   & ~bus.err_clr);
    end

    always_ff @(posedge slowClk or posedge reset) begin
        if (reset) begin
            clk_sync_q   <= 2'b11;
            dat_sync_q   <= 2'b11;
            fclk_q       <= 1'b1;
            filt_cnt_q   <= '0;
            state_q      <= IDLE;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            par_q        <= 1'b0;
            wd_q         <= '0;
            mem_q        <= '{default: 8'h00};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rx_pulse_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            dat_sync_q   <= dat_sync_d;
            fclk_q       <= fclk_d;
            filt_cnt_q   <= filt_cnt_d;
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            par_q        <= par_d;
            wd_q         <= wd_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rx_pulse_q   <= rx_pulse_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.dout       = not_empty ? mem_q[rd_ptr_q] : 8'h00;
    assign bus.valid      = not_empty;
    assign bus.count      = count_q;
    assign bus.rx_pulse   = rx_pulse_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: bit-banged PS/2 frames, byte scoreboard checked on every pop.
module tb_ps2_rx_fifo;
    localparam int DEPTH = 8;
    localparam int FL    = 4;
    localparam int TO    = 300;
    localparam int HALF  = 20;

    logic slowClk, reset, PS2data, PS2clk;
    int   checks, failures, pulses;
    logic [7:0] sb_q [$];

    ps2_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus();

    ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .slowClk(slowClk), .reset(reset), .PS2data(PS2data), .PS2clk(PS2clk), .bus(bus)
    );

    initial slowClk = 1'b0;
    always #5 slowClk = ~slowClk;

    always @(posedge slowClk) if (bus.rx_pulse === 1'b1) pulses++;

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed run still active, expected finish");
        $fatal(1, "time limit");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge slowClk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic b, input logic glitch);
        PS2data = b;
        cyc(8);
        if (glitch) begin
            PS2clk = 1'b0; cyc(2); PS2clk = 1'b1;
        end
        cyc(HALF - 8);
        PS2clk = 1'b0;
        cyc(HALF);
        PS2clk = 1'b1;
    endtask

    // Sends the first nbits of a frame; only complete good frames enter the scoreboard.
    task automatic send_frame(input logic [7:0] d, input logic par_bad, input logic stop,
                              input int glitch_bit, input int nbits);
        logic [10:0] fr;
        fr = {stop, (~^d) ^ par_bad, d, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(fr[i], i == glitch_bit);
        if (nbits == 11 && stop && !par_bad && sb_q.size() < DEPTH) sb_q.push_back(d);
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        check({tag, "_valid"}, bus.valid, 1);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_dout"}, bus.dout, e);
        end
        bus.rd_en = 1'b1; cyc(1); bus.rd_en = 1'b0;
    endtask

    task automatic clear_errs();
        bus.err_clr = 1'b1; cyc(1); bus.err_clr = 1'b0;
    endtask

    initial begin
        int p0;
        logic seen;
        logic [10:0] fr;
        checks = 0; failures = 0; pulses = 0;
        reset = 1'b1; PS2clk = 1'b1; PS2data = 1'b1;
        bus.rd_en = 1'b0; bus.err_clr = 1'b0;
        cyc(3);
        check("rst_dout", bus.dout, 8'h00);
        check("rst_valid", bus.valid, 0);
        check("rst_count", bus.count, 0);
        check("rst_flags", {bus.rx_pulse, bus.parity_err, bus.frame_err, bus.overflow}, 0);
        reset = 1'b0;
        cyc(4);

        // Good 0x1C, stop edge watched for push timing
        p0 = pulses;
        fr = {1'b1, 1'b0, 8'h1C, 1'b0};
        for (int i = 0; i < 10; i++) ps2_bit(fr[i], 1'b0);
        PS2data = 1'b1; cyc(HALF);
        PS2clk = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < HALF && !seen; i++) begin
            cyc(1);
            if (bus.rx_pulse === 1'b1) begin
                seen = 1'b1;
                check("push_valid", bus.valid, 1);
                check("push_dout", bus.dout, 8'h1C);
                check("push_count", bus.count, 1);
            end
        end
        check("push_seen", seen, 1);
        cyc(1);
        check("pulse_one_cycle", bus.rx_pulse, 0);
        cyc(HALF - 8); PS2clk = 1'b1; cyc(HALF);
        sb_q.push_back(8'h1C);
        check("g1c_pulses", pulses - p0, 1);
        check("g1c_flags", {bus.parity_err, bus.frame_err, bus.overflow}, 0);
        pop_check("g1c_pop");
        check("g1c_empty_valid", bus.valid, 0);
        check("g1c_empty_dout", bus.dout, 8'h00);

        // Parity error
        p0 = pulses;
        send_frame(8'h1C, 1'b1, 1'b1, -1, 11);
        check("par_err", bus.parity_err, 1);
        check("par_count", bus.count, 0);
        check("par_pulses", pulses - p0, 0);
        clear_errs();
        check("par_clr", bus.parity_err, 0);

        // Stop bit 0, then good 0xAA
        send_frame(8'hAA, 1'b0, 1'b0, -1, 11);
        check("stop_ferr", bus.frame_err, 1);
        check("stop_count", bus.count, 0);
        send_frame(8'hAA, 1'b0, 1'b1, -1, 11);
        check("aa_count", bus.count, 1);
        pop_check("aa_pop");
        clear_errs();
        check("ferr_clr", bus.frame_err, 0);

        // Overflow: nine good frames, no reads
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, -1, 11);
        check("ovf_count", bus.count, DEPTH);
        check("ovf_flag", bus.overflow, 1);
        for (int i = 0; i < DEPTH; i++) pop_check("ovf_pop");
        check("ovf_drained", bus.valid, 0);
        check("ovf_dout0", bus.dout, 8'h00);
        clear_errs();
        check("ovf_clr", bus.overflow, 0);

        // Watchdog: start + 4 data bits then clock idles high
        send_frame(8'h0F, 1'b0, 1'b1, -1, 5);
        cyc(TO / 2);
        check("wd_early", bus.frame_err, 0);
        cyc(TO);
        check("wd_ferr", bus.frame_err, 1);
        check("wd_count", bus.count, 0);
        clear_errs();
        send_frame(8'h5A, 1'b0, 1'b1, -1, 11);
        check("wd_next_flags", {bus.parity_err, bus.frame_err}, 0);
        pop_check("wd_5a");

        // Glitch on clock during data bits
        send_frame(8'h3C, 1'b0, 1'b1, 3, 11);
        check("gl_flags", {bus.parity_err, bus.frame_err}, 0);
        check("gl_count", bus.count, 1);
        check("gl_dout", bus.dout, 8'h3C);

        // Reset mid-frame with a byte stored
        send_frame(8'h99, 1'b0, 1'b1, -1, 5);
        @(negedge slowClk);
        reset = 1'b1;
        #1;
        check("mrst_dout", bus.dout, 8'h00);
        check("mrst_valid", bus.valid, 0);
        check("mrst_count", bus.count, 0);
        check("mrst_flags", {bus.rx_pulse, bus.parity_err, bus.frame_err, bus.overflow}, 0);
        sb_q.delete();
        cyc(2);
        reset = 1'b0;
        cyc(4);
        send_frame(8'h77, 1'b0, 1'b1, -1, 11);
        check("mrst_next_count", bus.count, 1);
        pop_check("mrst_77");
        check("mrst_end_valid", bus.valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
